// File: rtl/codec_tdm_intf.sv
// TDM/I2S codec serial interface: derives MCLK/SCLK/LRCLK/RSTn from one frame counter,
// serialises NUM_CH transmit channels onto SDin and deserialises SDout into NUM_CH receive channels.
module codec_tdm_intf #(
    parameter int DATA_W      = 16,
    parameter int SLOT_W      = 16,
    parameter int NUM_CH      = 2,
    parameter int SCLK_DIV    = 16,
    parameter int WARM_FRAMES = 1,
    parameter int I2S_DELAY   = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH*DATA_W-1:0]   tx_data_i,
    input  logic                       tx_valid_i,
    output logic                       tx_ready_o,
    output logic [NUM_CH*DATA_W-1:0]   rx_data_o,
    output logic                       rx_valid_o,
    output logic                       tx_underrun_o,
    output logic                       running_o,
    output logic                       mclk_o,
    output logic                       sclk_o,
    output logic                       lrclk_o,
    output logic                       rstn_o,
    output logic                       sdin_o,
    input  logic                       sdout_i
);

    localparam int DW_ALL = NUM_CH * DATA_W;
    localparam int CW     = $clog2(2 * SCLK_DIV * SLOT_W * NUM_CH);
    localparam int SB     = $clog2(SCLK_DIV);
    localparam int PW     = CW - SB - 1;
    localparam int SW     = $clog2(SLOT_W);
    localparam int MB     = (SCLK_DIV == 32'sd2) ? 32'sd0 : 32'sd1;

    localparam logic [SB:0]   RISE_PH  = (SB + 1)'(SCLK_DIV - 32'sd1);
    localparam logic [SB:0]   FALL_PH  = {(SB + 1){1'b1}};
    localparam logic [CW-1:0] CNT_LAST = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW - 1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] DELAY    = PW'(I2S_DELAY);
    localparam logic [3:0]    WARM_N   = 4'(WARM_FRAMES);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_WARM  = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    // Maps a stream position to a channel bit index (MSB first), or -1 for slot padding.
    function automatic int bit_index(input logic [PW-1:0] q);
        int j;
        int s;
        j = int'(q[SW-1:0]);
        s = int'(q[PW-1:SW]);
        if (j < DATA_W) begin
            bit_index = s * DATA_W + DATA_W - 32'sd1 - j;
        end else begin
            bit_index = -32'sd1;
        end
    endfunction

    function automatic logic pick_bit(input logic [DW_ALL-1:0] img, input int idx);
        logic b;
        b = 1'b0;
        for (int i = 32'sd0; i < DW_ALL; i++) begin
            b = b | (img[i] & (i == idx));
        end
        return b;
    endfunction

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [3:0]          warm_q, warm_d;
    logic [DW_ALL-1:0]   buf_q, buf_d;
    logic                buf_full_q, buf_full_d;
    logic [DW_ALL-1:0]   img_q, img_d;
    logic [DW_ALL-1:0]   rx_asm_q, rx_asm_d;
    logic [DW_ALL-1:0]   rx_data_q, rx_data_d;
    logic                sdin_q, sdin_d;
    logic                rx_valid_q, rx_valid_d;
    logic                underrun_q, underrun_d;
    logic                tx_ready_q, tx_ready_d;
    logic                rstn_q, rstn_d;
    logic                running_q, running_d;

    logic                boundary_s, rise_s, fall_s, accept_s;
    logic [PW-1:0]       p_cur_s, p_next_s;
    int                  tx_idx_s, rx_idx_s;

    assign boundary_s = (cnt_q == CNT_LAST);
    assign rise_s     = (cnt_q[SB:0] == RISE_PH);
    assign fall_s     = (cnt_q[SB:0] == FALL_PH);
    assign accept_s   = tx_valid_i & tx_ready_q;
    assign p_cur_s    = cnt_q[CW-1:SB+1];

    // Sequencer: codec reset frame, warm-up frames, then continuous run.
    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        case (state_q)
            ST_RESET: begin
                if (boundary_s) begin
                    warm_d  = 4'd0;
                    state_d = (WARM_FRAMES == 32'sd0) ? ST_RUN : ST_WARM;
                end else begin
                    state_d = ST_RESET;
                end
            end
            ST_WARM: begin
                if (boundary_s) begin
                    warm_d  = warm_q + 4'd1;
                    state_d = ((warm_q + 4'd1) == WARM_N) ? ST_RUN : ST_WARM;
                end else begin
                    state_d = ST_WARM;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_RESET;
        endcase
        rstn_d    = (state_d != ST_RESET);
        running_d = (state_d == ST_RUN);
    end

    // Datapath: transmit buffer/frame image, serial bit selection and receive assembly.
    always_comb begin
        cnt_d      = cnt_q + CNT_ONE;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        img_d      = img_q;
        rx_asm_d   = rx_asm_q;
        rx_data_d  = rx_data_q;
        sdin_d     = sdin_q;
        rx_valid_d = 1'b0;
        underrun_d = 1'b0;
        p_next_s   = cnt_d[CW-1:SB+1];
        tx_idx_s   = bit_index(p_next_s - DELAY);
        rx_idx_s   = bit_index(p_cur_s - DELAY);

        // Only frames that started in RUN are delivered; the image for the next frame is chosen here.
        if (boundary_s && (state_q == ST_RUN)) begin
            rx_data_d  = rx_asm_q;
            rx_valid_d = 1'b1;
            if (buf_full_q) begin
                img_d      = buf_q;
                buf_full_d = 1'b0;
            end else begin
                img_d      = {DW_ALL{1'b0}};
                underrun_d = 1'b1;
            end
        end else if (boundary_s) begin
            img_d = {DW_ALL{1'b0}};
        end else begin
            img_d = img_q;
        end

        if (accept_s) begin
            buf_d      = tx_data_i;
            buf_full_d = 1'b1;
        end else begin
            buf_d = buf_q;
        end

        if (fall_s) begin
            sdin_d = pick_bit(img_d, tx_idx_s);
        end else begin
            sdin_d = sdin_q;
        end

        if (rise_s) begin
            for (int i = 32'sd0; i < DW_ALL; i++) begin
                rx_asm_d[i] = (i == rx_idx_s) ? sdout_i : rx_asm_q[i];
            end
        end else begin
            rx_asm_d = rx_asm_q;
        end

        tx_ready_d = running_d & ~buf_full_d;
    end

    // State and datapath registers; rst_n clears everything, discarding any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RESET;
            cnt_q      <= {CW{1'b0}};
            warm_q     <= 4'd0;
            buf_q      <= {DW_ALL{1'b0}};
            buf_full_q <= 1'b0;
            img_q      <= {DW_ALL{1'b0}};
            rx_asm_q   <= {DW_ALL{1'b0}};
            rx_data_q  <= {DW_ALL{1'b0}};
            sdin_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            tx_ready_q <= 1'b0;
            rstn_q     <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            warm_q     <= warm_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            img_q      <= img_d;
            rx_asm_q   <= rx_asm_d;
            rx_data_q  <= rx_data_d;
            sdin_q     <= sdin_d;
            rx_valid_q <= rx_valid_d;
            underrun_q <= underrun_d;
            tx_ready_q <= tx_ready_d;
            rstn_q     <= rstn_d;
            running_q  <= running_d;
        end
    end

    assign mclk_o        = cnt_q[MB];
    assign sclk_o        = cnt_q[SB];
    assign lrclk_o       = ~cnt_q[CW-1];
    assign rstn_o        = rstn_q;
    assign sdin_o        = sdin_q;
    assign tx_ready_o    = tx_ready_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign tx_underrun_o = underrun_q;
    assign running_o     = running_q;

endmodule

// File: tb/tb_codec_tdm_intf.sv
// Directed bench for codec_tdm_intf: default stereo instance in loopback plus a
// 4-channel 24-in-32 I2S instance in loopback.
module tb_codec_tdm_intf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1_n, rst2_n;
    logic [31:0] tx_data1, rx_data1;
    logic        tx_valid1, tx_ready1, rx_valid1, und1, run1;
    logic        mclk1, sclk1, lrclk1, rstn1, sdin1;
    logic [95:0] tx_data2, rx_data2;
    logic        tx_valid2, tx_ready2, rx_valid2, und2, run2;
    logic        mclk2, sclk2, lrclk2, rstn2, sdin2;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] cyc1, cyc2;

    codec_tdm_intf u_dut (
        .clk(clk), .rst_n(rst1_n), .tx_data_i(tx_data1), .tx_valid_i(tx_valid1),
        .tx_ready_o(tx_ready1), .rx_data_o(rx_data1), .rx_valid_o(rx_valid1),
        .tx_underrun_o(und1), .running_o(run1), .mclk_o(mclk1), .sclk_o(sclk1),
        .lrclk_o(lrclk1), .rstn_o(rstn1), .sdin_o(sdin1), .sdout_i(sdin1)
    );

    codec_tdm_intf #(
        .DATA_W(24), .SLOT_W(32), .NUM_CH(4), .SCLK_DIV(2), .WARM_FRAMES(1), .I2S_DELAY(1)
    ) u_tdm (
        .clk(clk), .rst_n(rst2_n), .tx_data_i(tx_data2), .tx_valid_i(tx_valid2),
        .tx_ready_o(tx_ready2), .rx_data_o(rx_data2), .rx_valid_o(rx_valid2),
        .tx_underrun_o(und2), .running_o(run2), .mclk_o(mclk2), .sclk_o(sclk2),
        .lrclk_o(lrclk2), .rstn_o(rstn2), .sdin_o(sdin2), .sdout_i(sdin2)
    );

    // Bench-side cycle counters: clk edges since each reset release.
    always @(posedge clk or negedge rst1_n) begin
        if (!rst1_n) cyc1 <= 32'd0;
        else         cyc1 <= cyc1 + 32'd1;
    end

    always @(posedge clk or negedge rst2_n) begin
        if (!rst2_n) cyc2 <= 32'd0;
        else         cyc2 <= cyc2 + 32'd1;
    end

    task automatic goto1(input logic [31:0] t);
        while (cyc1 < t) @(negedge clk);
    endtask

    task automatic goto2(input logic [31:0] t);
        while (cyc2 < t) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if ({mclk1, sclk1, lrclk1, rstn1, sdin1, tx_ready1, rx_valid1, und1, run1} !== 9'b001000000) begin n_fail++; $display("FAIL reset_outputs got=%b exp=001000000", {mclk1, sclk1, lrclk1, rstn1, sdin1, tx_ready1, rx_valid1, und1, run1}); end
        n_checks++; if (rx_data1 !== 32'h0) begin n_fail++; $display("FAIL reset_rx_data got=%h exp=0", rx_data1); end
        rst1_n = 1'b1;
    endtask

    task automatic test_startup();
        logic [31:0] cv;
        goto1(32'd1023);
        n_checks++; if (rstn1 !== 1'b0) begin n_fail++; $display("FAIL rstn_at_1023 got=%b exp=0", rstn1); end
        goto1(32'd1024);
        n_checks++; if ({rstn1, run1, tx_ready1} !== 3'b100) begin n_fail++; $display("FAIL warm_entry got=%b exp=100", {rstn1, run1, tx_ready1}); end
        for (int c = 1024; c < 2048; c++) begin
            cv = 32'(c);
            goto1(cv);
            n_checks++; if ({mclk1, sclk1, lrclk1} !== {cv[1], cv[4], ~cv[9]}) begin n_fail++; $display("FAIL clocks cyc=%0d got=%b exp=%b", c, {mclk1, sclk1, lrclk1}, {cv[1], cv[4], ~cv[9]}); end
            n_checks++; if ({sdin1, rx_valid1, und1} !== 3'b000) begin n_fail++; $display("FAIL warm_quiet cyc=%0d got=%b exp=000", c, {sdin1, rx_valid1, und1}); end
        end
        n_checks++; if (run1 !== 1'b0) begin n_fail++; $display("FAIL running_at_2047 got=%b exp=0", run1); end
        goto1(32'd2048);
        n_checks++; if ({run1, tx_ready1, rx_valid1, und1} !== 4'b1100) begin n_fail++; $display("FAIL run_entry got=%b exp=1100", {run1, tx_ready1, rx_valid1, und1}); end
    endtask

    task automatic test_loopback();
        logic [15:0] w;
        int cyc;
        goto1(32'd2050);
        n_checks++; if (tx_ready1 !== 1'b1) begin n_fail++; $display("FAIL lb_ready got=%b exp=1", tx_ready1); end
        tx_data1  = 32'h3C3C_A5A5;
        tx_valid1 = 1'b1;
        goto1(32'd2051);
        tx_valid1 = 1'b0;
        n_checks++; if (tx_ready1 !== 1'b0) begin n_fail++; $display("FAIL lb_buffer_full got=%b exp=0", tx_ready1); end
        goto1(32'd3072);
        n_checks++; if ({und1, rx_valid1, tx_ready1} !== 3'b011) begin n_fail++; $display("FAIL lb_load_boundary got=%b exp=011", {und1, rx_valid1, tx_ready1}); end
        n_checks++; if (rx_data1 !== 32'h0) begin n_fail++; $display("FAIL lb_first_run_rx got=%h exp=0", rx_data1); end
        for (int p = 0; p < 32; p++) begin
            cyc = 3072 + p * 32 + 16;
            goto1(32'(cyc));
            w = (p < 16) ? 16'hA5A5 : 16'h3C3C;
            n_checks++; if (sdin1 !== w[15 - (p % 16)]) begin n_fail++; $display("FAIL lb_sdin bit=%0d got=%b exp=%b", p, sdin1, w[15 - (p % 16)]); end
            n_checks++; if (lrclk1 !== (p < 16)) begin n_fail++; $display("FAIL lb_lrclk bit=%0d got=%b exp=%b", p, lrclk1, (p < 16)); end
        end
        goto1(32'd4096);
        n_checks++; if (rx_data1 !== 32'h3C3C_A5A5) begin n_fail++; $display("FAIL lb_rx_data got=%h exp=3c3ca5a5", rx_data1); end
        n_checks++; if ({rx_valid1, und1} !== 2'b11) begin n_fail++; $display("FAIL lb_rx_pulse got=%b exp=11", {rx_valid1, und1}); end
        goto1(32'd4097);
        n_checks++; if ({rx_valid1, und1} !== 2'b00) begin n_fail++; $display("FAIL lb_pulse_width got=%b exp=00", {rx_valid1, und1}); end
    endtask

    task automatic test_underrun();
        int cyc;
        for (int p = 0; p < 32; p++) begin
            cyc = 4096 + p * 32 + 16;
            goto1(32'(cyc));
            n_checks++; if (sdin1 !== 1'b0) begin n_fail++; $display("FAIL ur_sdin bit=%0d got=%b exp=0", p, sdin1); end
        end
        goto1(32'd5120);
        n_checks++; if ({und1, rx_valid1} !== 2'b11) begin n_fail++; $display("FAIL ur_pulse got=%b exp=11", {und1, rx_valid1}); end
        n_checks++; if (rx_data1 !== 32'h0) begin n_fail++; $display("FAIL ur_rx_data got=%h exp=0", rx_data1); end
        goto1(32'd5121);
        n_checks++; if (und1 !== 1'b0) begin n_fail++; $display("FAIL ur_pulse_end got=%b exp=0", und1); end
    endtask

    task automatic test_boundary_accept();
        goto1(32'd6143);
        n_checks++; if ({tx_ready1, und1} !== 2'b10) begin n_fail++; $display("FAIL ba_pre got=%b exp=10", {tx_ready1, und1}); end
        tx_data1  = 32'h1234_5678;
        tx_valid1 = 1'b1;
        goto1(32'd6144);
        tx_valid1 = 1'b0;
        n_checks++; if ({und1, tx_ready1, rx_valid1} !== 3'b101) begin n_fail++; $display("FAIL ba_boundary got=%b exp=101", {und1, tx_ready1, rx_valid1}); end
        goto1(32'd6192);
        n_checks++; if (sdin1 !== 1'b0) begin n_fail++; $display("FAIL ba_zero_frame got=%b exp=0", sdin1); end
        goto1(32'd7168);
        n_checks++; if ({und1, rx_valid1} !== 2'b01) begin n_fail++; $display("FAIL ba_load got=%b exp=01", {und1, rx_valid1}); end
        goto1(32'd7216);
        n_checks++; if (sdin1 !== 1'b1) begin n_fail++; $display("FAIL ba_word_bit14 got=%b exp=1", sdin1); end
        goto1(32'd8192);
        n_checks++; if (rx_data1 !== 32'h1234_5678) begin n_fail++; $display("FAIL ba_rx_data got=%h exp=12345678", rx_data1); end
        n_checks++; if ({rx_valid1, und1} !== 2'b11) begin n_fail++; $display("FAIL ba_rx_pulse got=%b exp=11", {rx_valid1, und1}); end
    endtask

    task automatic test_reset_midframe();
        goto1(32'd8492);
        n_checks++; if ({run1, rstn1} !== 2'b11) begin n_fail++; $display("FAIL mr_pre got=%b exp=11", {run1, rstn1}); end
        rst1_n = 1'b0;
        #1;
        n_checks++; if ({mclk1, sclk1, lrclk1, rstn1, sdin1, tx_ready1, rx_valid1, und1, run1} !== 9'b001000000) begin n_fail++; $display("FAIL mr_outputs got=%b exp=001000000", {mclk1, sclk1, lrclk1, rstn1, sdin1, tx_ready1, rx_valid1, und1, run1}); end
        n_checks++; if (rx_data1 !== 32'h0) begin n_fail++; $display("FAIL mr_rx_data got=%h exp=0", rx_data1); end
        repeat (2) @(negedge clk);
        rst1_n = 1'b1;
        goto1(32'd1023);
        n_checks++; if ({rstn1, run1} !== 2'b00) begin n_fail++; $display("FAIL mr_reset_frame got=%b exp=00", {rstn1, run1}); end
        goto1(32'd1024);
        n_checks++; if ({rstn1, run1} !== 2'b10) begin n_fail++; $display("FAIL mr_warm got=%b exp=10", {rstn1, run1}); end
        goto1(32'd2048);
        n_checks++; if ({run1, tx_ready1, rx_valid1, und1} !== 4'b1100) begin n_fail++; $display("FAIL mr_run got=%b exp=1100", {run1, tx_ready1, rx_valid1, und1}); end
        goto1(32'd3072);
        n_checks++; if ({und1, rx_valid1} !== 2'b11) begin n_fail++; $display("FAIL mr_first_underrun got=%b exp=11", {und1, rx_valid1}); end
        n_checks++; if (rx_data1 !== 32'h0) begin n_fail++; $display("FAIL mr_rx_after got=%h exp=0", rx_data1); end
    endtask

    task automatic test_tdm_i2s();
        logic [23:0] ch [4];
        logic        exp;
        int q, s, j, cyc;
        ch[0] = 24'h800001;
        ch[1] = 24'h7FFFFF;
        ch[2] = 24'h123456;
        ch[3] = 24'hABCDEF;
        rst2_n = 1'b1;
        goto2(32'd1024);
        n_checks++; if ({run2, tx_ready2, rstn2} !== 3'b111) begin n_fail++; $display("FAIL tdm_run_entry got=%b exp=111", {run2, tx_ready2, rstn2}); end
        goto2(32'd1025);
        n_checks++; if ({mclk2, sclk2} !== 2'b10) begin n_fail++; $display("FAIL tdm_mclk got=%b exp=10", {mclk2, sclk2}); end
        goto2(32'd1030);
        tx_data2  = {ch[3], ch[2], ch[1], ch[0]};
        tx_valid2 = 1'b1;
        goto2(32'd1031);
        tx_valid2 = 1'b0;
        n_checks++; if (tx_ready2 !== 1'b0) begin n_fail++; $display("FAIL tdm_buffer_full got=%b exp=0", tx_ready2); end
        for (int p = 0; p < 128; p++) begin
            cyc = 1536 + p * 4 + 2;
            goto2(32'(cyc));
            q = (p + 127) % 128;
            s = q / 32;
            j = q % 32;
            exp = (j < 24) ? ch[s][23 - j] : 1'b0;
            n_checks++; if (sdin2 !== exp) begin n_fail++; $display("FAIL tdm_sdin bit=%0d got=%b exp=%b", p, sdin2, exp); end
            n_checks++; if (lrclk2 !== (p < 64)) begin n_fail++; $display("FAIL tdm_lrclk bit=%0d got=%b exp=%b", p, lrclk2, (p < 64)); end
            if (p % 32 == 1) begin
                n_checks++; if (sdin2 !== ch[p / 32][23]) begin n_fail++; $display("FAIL tdm_msb_delay slot=%0d got=%b exp=%b", p / 32, sdin2, ch[p / 32][23]); end
            end
        end
        goto2(32'd2048);
        n_checks++; if (rx_data2 !== 96'hABCDEF_123456_7FFFFF_800001) begin n_fail++; $display("FAIL tdm_rx_data got=%h exp=abcdef1234567fffff800001", rx_data2); end
        n_checks++; if ({rx_valid2, und2} !== 2'b11) begin n_fail++; $display("FAIL tdm_rx_pulse got=%b exp=11", {rx_valid2, und2}); end
    endtask

    initial begin
        rst1_n    = 1'b0;
        rst2_n    = 1'b0;
        tx_data1  = 32'h0;
        tx_valid1 = 1'b0;
        tx_data2  = 96'h0;
        tx_valid2 = 1'b0;
        test_reset();
        test_startup();
        test_loopback();
        test_underrun();
        test_boundary_accept();
        test_reset_midframe();
        test_tdm_i2s();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/codec_tdm_intf.md
# codec_tdm_intf

Parametrised successor to the stereo codec serial interface. Generates MCLK, SCLK, LRCLK (frame sync) and codec RSTn from `clk`. Serialises `NUM_CH` transmit channels onto SDin and deserialises SDout into `NUM_CH` receive channels. Adds configurable sample and slot width, TDM channel count, optional I2S one-bit delay, a warm-up period, and a valid/ready transmit handshake with underrun reporting. Sits between the audio datapath and the external codec pins.

## Interface
- DATA_W, 16: sample width in bits, 8..32.
- SLOT_W, 16: SCLK periods per channel slot, power of 2; must satisfy SLOT_W >= DATA_W + I2S_DELAY.
- NUM_CH, 2: channels per frame, power of 2, >= 2.
- SCLK_DIV, 16: clk cycles per SCLK half-period, power of 2, >= 2.
- WARM_FRAMES, 1: frames run after codec reset release before data transfer starts, 0..15.
- I2S_DELAY, 0: 0 = left-justified; 1 = MSB one SCLK period after the slot boundary.
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- tx_data  in  NUM_CH*DATA_W  transmit frame; channel k is bits [k*DATA_W +: DATA_W].
- tx_valid  in  1  tx_data is offered.
- tx_ready  out  1  transmit buffer can accept a word.
- rx_data  out  NUM_CH*DATA_W  last received frame, same channel packing as tx_data.
- rx_valid  out  1  one-cycle pulse when rx_data is updated.
- tx_underrun  out  1  one-cycle pulse when a frame is sent with no buffered data.
- running  out  1  high in RUN.
- MCLK, SCLK, LRCLK, RSTn, SDin  out  1  codec pins.
- SDout  in  1  serial data from the codec.

## Operation
- Free-running counter `cnt`:
  - Width CW = log2(2*SCLK_DIV*SLOT_W*NUM_CH); reset to 0; increments every clk from the first cycle after rst_n deasserts.
  - A frame is 2^CW clk cycles. The frame boundary is the edge at which cnt = all-ones.
- Clock outputs, with SB = log2(SCLK_DIV):
  - MCLK = cnt[0] when SCLK_DIV = 2, otherwise cnt[1].
  - SCLK = cnt[SB].
  - LRCLK = ~cnt[CW-1], so it is high for channels 0..NUM_CH/2-1.
- Bit period index p = cnt[CW-1:SB+1].
- Serial mapping:
  - Stream position q = p − I2S_DELAY, taken modulo the frame.
  - Slot s = q / SLOT_W; bit j = q % SLOT_W.
  - For j < DATA_W the bit is channel s, bit DATA_W-1-j (MSB first). For j >= DATA_W the bit is padding: 0 on SDin, ignored on SDout.
- TX path:
  - SDin is registered and updates on the edge at which SCLK falls (cnt[SB:0] = all-ones).
  - At each frame boundary in RUN, the output shift image loads from the buffer if it is full, and the buffer empties.
  - If the buffer is empty at that boundary, the frame is all zeros and tx_underrun pulses.
- RX path:
  - SDout is sampled on the edge at which SCLK rises (cnt[SB:0] = SCLK_DIV-1).
  - At each frame boundary that ends a frame which started in RUN, the assembled channels copy to rx_data and rx_valid is high the next cycle (cnt = 0).
- Handshake:
  - tx_ready = running & buffer empty.
  - A transfer occurs on any cycle with tx_valid & tx_ready.
  - Buffer depth is 1 frame.
- State machine:
  - RESET: RSTn = 0 for the first full frame. At the frame boundary go to WARM, or to RUN if WARM_FRAMES = 0. RSTn = 1 from cnt = 0 of the next frame.
  - WARM: clocks run, SDin = 0, no rx_valid, tx_ready = 0. Leave after WARM_FRAMES frame boundaries, then go to RUN.
  - RUN: the first RUN frame transmits zeros and does not flag underrun. Every later frame boundary loads or underruns.
- Boundary conditions:
  - Buffer empty at a boundary with tx_valid in the same cycle: underrun is flagged for this frame, the word is accepted, and it is sent next frame.
  - rst_n asserted mid-frame: all state clears immediately and asynchronously; the partially received frame is discarded with no rx_valid.
  - The buffer never overwrites: tx_valid while tx_ready = 0 is held by the source.

## Timing
- Reset values:
  - cnt = 0, MCLK = SCLK = 0, LRCLK = 1.
  - RSTn = 0, SDin = 0.
  - tx_ready = 0, rx_valid = 0, tx_underrun = 0, running = 0.
  - rx_data = 0.
- With defaults, a frame is 1024 clk cycles, SCLK period is 32, and MCLK period is 4.
- Loopback (SDout = SDin): a word written during frame N-1 is sent in frame N, appears on rx_data, and rx_valid pulses at cnt = 0 of frame N+1.
- tx_underrun and rx_valid are registered and coincide at cnt = 0.

## Test plan
- Defaults, release rst_n → RSTn rises at clk 1024, running rises at 2048, LRCLK/SCLK/MCLK periods are 1024/32/4 with LRCLK high for the first 512.
- Defaults, loopback, write {0x3C3C, 0xA5A5} → rx_data = 0x3C3CA5A5 one frame after transmission, and LRCLK high while 0xA5A5 bits are on SDin.
- No tx_valid in RUN → tx_underrun pulses each frame boundary after the first RUN frame, SDin stays 0, rx_data = 0.
- NUM_CH=4, SLOT_W=32, DATA_W=24, I2S_DELAY=1, loopback, channels 0x800001/0x7FFFFF/0x123456/0xABCDEF → received exactly; each MSB appears one SCLK after its slot boundary.
- Buffer empty, tx_valid at the boundary cycle → tx_underrun pulse, and the word appears in the following frame.
- rst_n pulsed low at cnt = 300 in RUN → all outputs return to reset values immediately, and the full RESET/WARM sequence repeats.
